// File: rtl/md_unit_if.sv
// Handshake and result bus between the execute-stage controller and md_unit.
// The controller drives the master side; md_unit owns the slave side.
interface md_unit_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       md_op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, md_op, a, b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, md_op, a, b,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for mult/multu/div/divu/mthi/mtlo.
// The result is computed when an op is accepted and held back until its busy window expires.
module md_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic     clk,
    input  logic     reset,
    md_unit_if.slave md_if
);
    localparam int MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CntW      = $clog2(MaxCycles + 1);

    typedef enum logic [2:0] {
        OpNone  = 3'd0,
        OpMult  = 3'd1,
        OpMultu = 3'd2,
        OpDiv   = 3'd3,
        OpDivu  = 3'd4,
        OpMthi  = 3'd5,
        OpMtlo  = 3'd6,
        OpRsvd  = 3'd7
    } mdOp_e;

    mdOp_e            op;
    logic [CntW-1:0]  count_q, count_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] pendHi_q, pendHi_d, pendLo_q, pendLo_d;
    logic             divZero_q, divZero_d;
    logic             done_q, done_d;

    logic [2*WIDTH-1:0] prodSigned, prodUnsigned;
    logic               signA, signB, bZero;
    logic [WIDTH-1:0]   magA, magB, divisorS, divisorU;
    logic [WIDTH-1:0]   quotMag, remMag, quotS, remS, quotU, remU;

    assign op    = mdOp_e'(md_if.md_op);
    assign signA = md_if.a[WIDTH-1];
    assign signB = md_if.b[WIDTH-1];
    assign bZero = (md_if.b == '0);

    assign prodSigned   = {{WIDTH{signA}}, md_if.a} * {{WIDTH{signB}}, md_if.b};
    assign prodUnsigned = {{WIDTH{1'b0}}, md_if.a} * {{WIDTH{1'b0}}, md_if.b};

    // Signed divide works on magnitudes; the most negative dividend maps onto itself,
    // which as an unsigned magnitude is exactly 2^(WIDTH-1), so overflow falls out naturally.
    assign magA     = signA ? -md_if.a : md_if.a;
    assign magB     = signB ? -md_if.b : md_if.b;
    assign divisorS = bZero ? WIDTH'(1) : magB;
    assign divisorU = bZero ? WIDTH'(1) : md_if.b;
    assign quotMag  = magA / divisorS;
    assign remMag   = magA % divisorS;
    assign quotS    = (signA ^ signB) ? -quotMag : quotMag;
    assign remS     = signA ? -remMag : remMag;
    assign quotU    = md_if.a / divisorU;
    assign remU     = md_if.a % divisorU;

    always_comb begin
        count_d   = count_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pendHi_d  = pendHi_q;
        pendLo_d  = pendLo_q;
        divZero_d = divZero_q;
        done_d    = 1'b0;

        if (count_q != '0) begin
            count_d = count_q - CntW'(1);
            if (count_q == CntW'(1)) begin
                done_d = 1'b1;
                if (!divZero_q) begin
                    hi_d = pendHi_q;
                    lo_d = pendLo_q;
                end
            end
        end else if (md_if.start) begin
            case (op)
                OpMult: begin
                    {pendHi_d, pendLo_d} = prodSigned;
                    divZero_d            = 1'b0;
                    count_d              = CntW'(MULT_CYCLES);
                end
                OpMultu: begin
                    {pendHi_d, pendLo_d} = prodUnsigned;
                    divZero_d            = 1'b0;
                    count_d              = CntW'(MULT_CYCLES);
                end
                OpDiv: begin
                    pendHi_d  = remS;
                    pendLo_d  = quotS;
                    divZero_d = bZero;
                    count_d   = CntW'(DIV_CYCLES);
                end
                OpDivu: begin
                    pendHi_d  = remU;
                    pendLo_d  = quotU;
                    divZero_d = bZero;
                    count_d   = CntW'(DIV_CYCLES);
                end
                OpMthi:  hi_d = md_if.a;
                OpMtlo:  lo_d = md_if.a;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            pendHi_q  <= '0;
            pendLo_q  <= '0;
            divZero_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pendHi_q  <= pendHi_d;
            pendLo_q  <= pendLo_d;
            divZero_q <= divZero_d;
            done_q    <= done_d;
        end
    end

    assign md_if.busy = (count_q != '0);
    assign md_if.done = done_q;
    assign md_if.hi   = hi_q;
    assign md_if.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: a 32-bit default instance and an 8-bit short-latency instance.
// Expected HI/LO and busy lengths are queued at issue and compared when done pulses.
module tb_md_unit;
    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } expEntry_t;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    expEntry_t   sb32[$];
    expEntry_t   sb8[$];
    expEntry_t   e32, e8;
    int          busyRun32, busyRun8;
    logic [31:0] m32Hi, m32Lo, m8Hi, m8Lo;
    logic [31:0] prevHi, prevLo;

    md_unit_if #(.WIDTH(32)) bus32 ();
    md_unit_if #(.WIDTH(8))  bus8 ();

    md_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut32 (
        .clk   (clk),
        .reset (reset),
        .md_if (bus32)
    );

    md_unit #(.WIDTH(8), .MULT_CYCLES(1), .DIV_CYCLES(3)) dut8 (
        .clk   (clk),
        .reset (reset),
        .md_if (bus8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    // Independent reference: 64-bit sign/zero-extended arithmetic, masked to the instance width.
    function automatic logic [63:0] refModel(input int w, input logic [2:0] op,
                                             input logic [31:0] a, input logic [31:0] b,
                                             input logic [31:0] oldHi, input logic [31:0] oldLo);
        logic signed [63:0] sa, sb, p, q, r;
        logic [31:0] mask, ai, bi, hiR, loR;
        mask = (w == 8) ? 32'h0000_00FF : 32'hFFFF_FFFF;
        ai   = a & mask;
        bi   = b & mask;
        if (op == 3'd1 || op == 3'd3) begin
            sa = (w == 8) ? {{56{ai[7]}}, ai[7:0]} : {{32{ai[31]}}, ai};
            sb = (w == 8) ? {{56{bi[7]}}, bi[7:0]} : {{32{bi[31]}}, bi};
        end else begin
            sa = {32'h0, ai};
            sb = {32'h0, bi};
        end
        hiR = oldHi;
        loR = oldLo;
        if (op == 3'd1 || op == 3'd2) begin
            p   = sa * sb;
            loR = p[31:0] & mask;
            hiR = 32'(p >> w) & mask;
        end else if ((op == 3'd3 || op == 3'd4) && bi != 32'h0) begin
            q   = sa / sb;
            r   = sa % sb;
            loR = q[31:0] & mask;
            hiR = r[31:0] & mask;
        end
        return {hiR, loR};
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            #2;
        end
    endtask

    // Drives one start cycle; when the op should be accepted the model and scoreboard are updated.
    task automatic applyStimulus(input bit sel8, input logic [2:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input bit expectAccept);
        logic [63:0] res;
        int          w;
        w = sel8 ? 8 : 32;
        if (sel8) begin
            bus8.start = 1'b1;
            bus8.md_op = op;
            bus8.a     = a[7:0];
            bus8.b     = b[7:0];
        end else begin
            bus32.start = 1'b1;
            bus32.md_op = op;
            bus32.a     = a;
            bus32.b     = b;
        end
        if (expectAccept) begin
            if (op >= 3'd1 && op <= 3'd4) begin
                if (sel8) begin
                    res  = refModel(w, op, a, b, m8Hi, m8Lo);
                    m8Hi = res[63:32];
                    m8Lo = res[31:0];
                    sb8.push_back('{res[63:32], res[31:0], (op <= 3'd2) ? 1 : 3});
                end else begin
                    res   = refModel(w, op, a, b, m32Hi, m32Lo);
                    m32Hi = res[63:32];
                    m32Lo = res[31:0];
                    sb32.push_back('{res[63:32], res[31:0], (op <= 3'd2) ? 5 : 10});
                end
            end else if (op == 3'd5) begin
                if (sel8) m8Hi = a & 32'hFF; else m32Hi = a;
            end else if (op == 3'd6) begin
                if (sel8) m8Lo = a & 32'hFF; else m32Lo = a;
            end
        end
        @(posedge clk);
        #1;
        bus32.start = 1'b0;
        bus8.start  = 1'b0;
        bus32.a     = $urandom;
        bus32.b     = $urandom;
        bus8.a      = 8'($urandom);
        bus8.b      = 8'($urandom);
        @(negedge clk);
        #2;
    endtask

    task automatic waitDrain(input bit sel8);
        int n;
        n = 0;
        while (n < 100 && (sel8 ? (sb8.size() != 0 || bus8.busy) : (sb32.size() != 0 || bus32.busy))) begin
            tick(1);
            n++;
        end
        checkOutput(sel8 ? "drain8" : "drain32", sel8 ? sb8.size() : sb32.size(), 0);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            busyRun32 = 0;
        end else begin
            if (bus32.busy) busyRun32++;
            if (bus32.done) begin
                checkOutput("donePending32", sb32.size() != 0, 1);
                if (sb32.size() != 0) begin
                    e32 = sb32.pop_front();
                    checkOutput("hi32", bus32.hi, e32.hi);
                    checkOutput("lo32", bus32.lo, e32.lo);
                    checkOutput("busyLen32", busyRun32, e32.cycles);
                end
                busyRun32 = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            busyRun8 = 0;
        end else begin
            if (bus8.busy) busyRun8++;
            if (bus8.done) begin
                checkOutput("donePending8", sb8.size() != 0, 1);
                if (sb8.size() != 0) begin
                    e8 = sb8.pop_front();
                    checkOutput("hi8", bus8.hi, e8.hi);
                    checkOutput("lo8", bus8.lo, e8.lo);
                    checkOutput("busyLen8", busyRun8, e8.cycles);
                end
                busyRun8 = 0;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        m32Hi = '0; m32Lo = '0; m8Hi = '0; m8Lo = '0;
        bus32.start = 1'b0; bus32.md_op = 3'd0; bus32.a = '0; bus32.b = '0;
        bus8.start  = 1'b0; bus8.md_op  = 3'd0; bus8.a  = '0; bus8.b  = '0;
        reset = 1'b1;
        tick(2);
        checkOutput("rstHi32", bus32.hi, 0);
        checkOutput("rstLo32", bus32.lo, 0);
        checkOutput("rstBusy32", bus32.busy, 0);
        checkOutput("rstDone32", bus32.done, 0);
        checkOutput("rstBusy8", bus8.busy, 0);
        reset = 1'b0;
        tick(1);

        prevHi = m32Hi;
        applyStimulus(0, 3'd1, 32'hFFFF_FFFF, 32'd2, 1);
        checkOutput("busyAfterAccept", bus32.busy, 1);
        checkOutput("holdHiWhileBusy", bus32.hi, prevHi);
        waitDrain(0);
        applyStimulus(0, 3'd2, 32'hFFFF_FFFF, 32'd2, 1);
        waitDrain(0);

        applyStimulus(0, 3'd3, 32'hFFFF_FFF9, 32'd2, 1);
        waitDrain(0);
        applyStimulus(0, 3'd4, 32'd7, 32'd2, 1);
        waitDrain(0);
        applyStimulus(0, 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1);
        waitDrain(0);

        applyStimulus(0, 3'd5, 32'h1111_1111, 32'd0, 1);
        checkOutput("mthi", bus32.hi, 32'h1111_1111);
        checkOutput("mthiBusy", bus32.busy, 0);
        applyStimulus(0, 3'd6, 32'h2222_2222, 32'd0, 1);
        checkOutput("mtlo", bus32.lo, 32'h2222_2222);
        checkOutput("mtloDone", bus32.done, 0);
        applyStimulus(0, 3'd3, 32'd123, 32'd0, 1);
        tick(4);
        checkOutput("divZeroBusy", bus32.busy, 1);
        waitDrain(0);
        applyStimulus(0, 3'd0, 32'd5, 32'd5, 0);
        checkOutput("opNoneBusy", bus32.busy, 0);
        checkOutput("opNoneHi", bus32.hi, m32Hi);

        prevLo = m32Lo;
        applyStimulus(0, 3'd1, 32'd3, 32'd7, 1);
        tick(1);
        applyStimulus(0, 3'd4, 32'd100, 32'd3, 0);
        applyStimulus(0, 3'd6, 32'h0000_DEAD, 32'd0, 0);
        checkOutput("mtloIgnored", bus32.lo, prevLo);
        waitDrain(0);
        applyStimulus(0, 3'd2, 32'd5, 32'd6, 1);
        checkOutput("acceptAfterCommit", bus32.busy, 1);
        waitDrain(0);

        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 3'($urandom_range(1, 4)), $urandom, $urandom, 1);
            waitDrain(0);
        end

        applyStimulus(0, 3'd3, 32'd100, 32'd7, 1);
        tick(3);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abortBusy", bus32.busy, 0);
        checkOutput("abortHi", bus32.hi, 0);
        checkOutput("abortLo", bus32.lo, 0);
        checkOutput("abortDone", bus32.done, 0);
        @(negedge clk);
        #2;
        reset = 1'b0;
        sb32.delete();
        sb8.delete();
        m32Hi = '0; m32Lo = '0; m8Hi = '0; m8Lo = '0;
        tick(15);
        checkOutput("abortIdle", bus32.busy, 0);

        applyStimulus(1, 3'd1, 32'h80, 32'h80, 1);
        checkOutput("busy8", bus8.busy, 1);
        waitDrain(1);
        applyStimulus(1, 3'd3, 32'h80, 32'hFF, 1);
        waitDrain(1);
        applyStimulus(1, 3'd7, 32'h55, 32'h55, 0);
        checkOutput("rsvdBusy8", bus8.busy, 0);
        checkOutput("rsvdHi8", bus8.hi, m8Hi);
        checkOutput("rsvdLo8", bus8.lo, m8Lo);
        tick(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
